fifo_link_buffer: RTL and testbench



---
 rtl/fifo_link_buffer_if.sv | 24 ++
 rtl/fifo_link_buffer.sv | 108 ++++++++++
 tb/tb_fifo_link_buffer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fifo_link_buffer_if.sv
// Producer/consumer link bundle for fifo_link_buffer.
// The master side drives requests and data; the slave side is the FIFO.
interface fifo_link_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) ();
    logic                       write;
    logic [WIDTH-1:0]           datain;
    logic                       read;
    logic [WIDTH-1:0]           dataout;
    logic                       empty;
    logic                       full;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output write, datain, read,
        input  dataout, empty, full, count
    );

    modport slave (
        input  write, datain, read,
        output dataout, empty, full, count
    );
endinterface

// File: rtl/fifo_link_buffer.sv
// Single-clock FIFO for 32-bit link words.
// Supports first-word-fallthrough output and a circular replay mode that rotates stored words.
module fifo_link_buffer #(
    parameter int WIDTH                 = 32,
    parameter int DEPTH                 = 2,
    parameter int FIRSTWORD_FALLTHROUGH = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               circular,
    fifo_link_buffer_if.slave  link
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic             empty_q;
    logic             full_q;
    logic             rd_acc;
    logic             wr_acc;
    logic             rotate;

    // In circular mode a read occupies the write port, so an external write only gets in on idle-read cycles.
    always_comb begin
        rd_acc     = link.read && !empty_q;
        rotate     = circular && rd_acc;
        wr_acc     = 1'b0;
        count_next = count_q;
        if (circular) begin
            wr_acc = link.write && !full_q && !rd_acc;
        end else begin
            wr_acc = link.write && (!full_q || rd_acc);
        end
        if (wr_acc && !rd_acc) begin
            count_next = count_q + CW'(1);
        end else if (rd_acc && !wr_acc && !circular) begin
            count_next = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (wr_acc || rotate) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_next;
            empty_q <= (count_next == '0);
            full_q  <= (count_next == CW'(DEPTH));
        end
    end

    // Storage needs no reset: a slot is only ever observed after it has been written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (rotate) begin
                mem[wr_ptr] <= mem[rd_ptr];
            end else if (wr_acc) begin
                mem[wr_ptr] <= link.datain;
            end
        end
    end

    generate
        if (FIRSTWORD_FALLTHROUGH != 0) begin : g_fwft
            logic [WIDTH-1:0] shown_q;

            // Remember the head on display so the output holds it once the FIFO drains.
            always_ff @(posedge clk) begin
                if (reset) begin
                    shown_q <= '0;
                end else if (!empty_q) begin
                    shown_q <= mem[rd_ptr];
                end
            end

            assign link.dataout = empty_q ? shown_q : mem[rd_ptr];
        end else begin : g_registered
            logic [WIDTH-1:0] dataout_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    dataout_q <= '0;
                end else if (rd_acc) begin
                    dataout_q <= mem[rd_ptr];
                end
            end

            assign link.dataout = dataout_q;
        end
    endgenerate

    assign link.empty = empty_q;
    assign link.full  = full_q;
    assign link.count = count_q;
endmodule

// File: tb/tb_fifo_link_buffer.sv
// Directed bench for fifo_link_buffer: FWFT and registered-read instances share stimulus
// and are compared every cycle against a queue model, plus literal spot checks.
module tb_fifo_link_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst;
    logic             circ;
    logic             w;
    logic             r;
    logic [WIDTH-1:0] d;

    int tests;
    int fails;

    fifo_link_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) link1 ();
    fifo_link_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) link0 ();

    assign link1.write  = w;
    assign link1.datain = d;
    assign link1.read   = r;
    assign link0.write  = w;
    assign link0.datain = d;
    assign link0.read   = r;

    fifo_link_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIRSTWORD_FALLTHROUGH(1)) dut1 (
        .clk      (clk),
        .reset    (rst),
        .circular (circ),
        .link     (link1.slave)
    );

    fifo_link_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIRSTWORD_FALLTHROUGH(0)) dut0 (
        .clk      (clk),
        .reset    (rst),
        .circular (circ),
        .link     (link0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] mLast;
    logic [WIDTH-1:0] mOut0;
    logic [WIDTH-1:0] mHead;
    bit               mRdOk;
    bit               mWrOk;
    bit               modelValid = 1'b0;

    // Model works on a queue of words: the front is the head, rotation is pop-then-push.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mLast      = '0;
            mOut0      = '0;
            modelValid = 1'b1;
        end else begin
            if (mq.size() > 0) mLast = mq[0];
            mRdOk = r && (mq.size() > 0);
            if (circ) mWrOk = w && (mq.size() < DEPTH) && !mRdOk;
            else      mWrOk = w && ((mq.size() < DEPTH) || mRdOk);
            if (mRdOk) begin
                mHead = mq.pop_front();
                mOut0 = mHead;
                if (circ) mq.push_back(mHead);
            end
            if (mWrOk) mq.push_back(d);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("m1.empty", 32'(link1.empty), 32'(mq.size() == 0));
            checkOutput("m1.full",  32'(link1.full),  32'(mq.size() == DEPTH));
            checkOutput("m1.count", 32'(link1.count), 32'(mq.size()));
            checkOutput("m1.dout",  link1.dataout, (mq.size() > 0) ? mq[0] : mLast);
            checkOutput("m0.empty", 32'(link0.empty), 32'(mq.size() == 0));
            checkOutput("m0.full",  32'(link0.full),  32'(mq.size() == DEPTH));
            checkOutput("m0.count", 32'(link0.count), 32'(mq.size()));
            checkOutput("m0.dout",  link0.dataout, mOut0);
        end
    end

    task automatic applyStimulus(input bit iw, input logic [31:0] id, input bit ir,
                                 input bit ic, input bit irst);
        w    = iw;
        d    = id;
        r    = ir;
        circ = ic;
        rst  = irst;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        w = 0; d = '0; r = 0; circ = 0; rst = 1;

        // Reset and read-on-empty
        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(0, 32'h0, 0, 0, 1);
        checkOutput("rst.empty", 32'(link1.empty), 32'd1);
        checkOutput("rst.full",  32'(link1.full),  32'd0);
        checkOutput("rst.count", 32'(link1.count), 32'd0);
        checkOutput("rst.dout1", link1.dataout, 32'h0);
        checkOutput("rst.dout0", link0.dataout, 32'h0);
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("rdempty.empty", 32'(link1.empty), 32'd1);
        checkOutput("rdempty.dout",  link1.dataout, 32'h0);

        // Write with read on empty: write wins, then drain
        applyStimulus(1, 32'h9, 1, 0, 0);
        checkOutput("wr9.count", 32'(link1.count), 32'd1);
        checkOutput("wr9.dout",  link1.dataout, 32'h9);
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("drain9.empty", 32'(link1.empty), 32'd1);
        checkOutput("drain9.dout1", link1.dataout, 32'h9);
        checkOutput("drain9.dout0", link0.dataout, 32'h9);

        // Fill to full, overflow write dropped
        applyStimulus(1, 32'hA, 0, 0, 0);
        applyStimulus(1, 32'hE, 0, 0, 0);
        checkOutput("fill.full", 32'(link1.full), 32'd1);
        applyStimulus(1, 32'h47F, 0, 0, 0);
        checkOutput("ovf.count", 32'(link1.count), 32'd2);
        checkOutput("ovf.full",  32'(link1.full),  32'd1);
        checkOutput("ovf.dout",  link1.dataout, 32'hA);

        // Circular replay
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 32'h0, 1, 1, 0);
            checkOutput("rot.dout",  link1.dataout, (i % 2 == 0) ? 32'hE : 32'hA);
            checkOutput("rot.full",  32'(link1.full),  32'd1);
            checkOutput("rot.count", 32'(link1.count), 32'd2);
        end

        // Write during rotation is dropped, then normal drain
        applyStimulus(1, 32'h0, 1, 1, 0);
        checkOutput("rotwr.dout",  link1.dataout, 32'hE);
        checkOutput("rotwr.count", 32'(link1.count), 32'd2);
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("dr1.dout",  link1.dataout, 32'hA);
        checkOutput("dr1.dout0", link0.dataout, 32'hE);
        checkOutput("dr1.count", 32'(link1.count), 32'd1);
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("dr2.empty", 32'(link1.empty), 32'd1);
        checkOutput("dr2.dout",  link1.dataout, 32'hA);
        checkOutput("dr2.dout0", link0.dataout, 32'hA);

        // Registered-read latency and mid-fill reset
        applyStimulus(1, 32'h5, 0, 0, 0);
        checkOutput("reg.hold", link0.dataout, 32'hA);
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("reg.dout", link0.dataout, 32'h5);
        applyStimulus(1, 32'h6, 0, 0, 0);
        applyStimulus(1, 32'h7, 0, 0, 1);
        checkOutput("midrst.empty", 32'(link0.empty), 32'd1);
        checkOutput("midrst.count", 32'(link0.count), 32'd0);
        checkOutput("midrst.dout0", link0.dataout, 32'h0);
        checkOutput("midrst.dout1", link1.dataout, 32'h0);
        applyStimulus(0, 32'h0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
